seq_mul_top: RTL and testbench
==============================

# seq_mul_top

Sequential fixed-point shift-add multiplier with the same start/busy/valid/ov handshake as the divider (`div_top`). It is the inverse datapath of the divider: same operand format, same launch and result protocol. The two blocks are interchangeable behind one controller, and products can be checked by dividing back. It computes one W-bit product over W cycles, one partial product per cycle.

## Interface
Parameters:
- `W`, 10: operand and result width, unsigned.
- `FRAC`, 5: number of fractional bits in the operands and the result (Q(W-FRAC).FRAC).

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: launch request. Only its rising edge launches a multiply.
- `A`, in, W: multiplicand, sampled at launch.
- `B`, in, W: multiplier, sampled at launch.
- `Q`, out, W: product, `(A*B) >> FRAC`, truncated.
- `busy`, out, 1: high while a multiply is in progress.
- `valid`, out, 1: high when `Q`/`ov` hold a finished result. Sticky until the next launch or reset.
- `ov`, out, 1: overflow. Set when the product does not fit in W integer+fraction bits.

## Operation
- Launch condition: `start`=1, `start_d`=0 (registered previous value), and state is IDLE or DONE.
- On launch: latch `A` into `a_r` (2W bits, zero-extended) and `B` into `b_r`; clear `acc` (2W bits) and `cnt`; clear `valid` and `ov`; go to RUN.
- Holding `start` high never relaunches.
- State machine, 3 states:
  - IDLE: waits for launch.
  - RUN: on each cycle, if `b_r[0]` then `acc` ← `acc + a_r`. Then `a_r` ← `a_r << 1`, `b_r` ← `b_r >> 1`, `cnt`++. When `cnt` = W-1 on this cycle, go to DONE.
  - DONE: holds `Q`, `ov` and `valid`=1. A launch is accepted here exactly as in IDLE.
- Result capture on the final RUN cycle, using the final `acc`:
  - `Q` ← `acc[FRAC+W-1:FRAC]`.
  - `ov` ← OR of `acc[2W-1:FRAC+W]`.
  - On overflow `Q` still carries the truncated low bits; it does not saturate.
- `busy` = (state == RUN), registered.
- A `start` rising edge during RUN is ignored and not queued.
- `A` and `B` may change freely after launch.

## Timing
- Reset values: `Q`=0, `busy`=0, `valid`=0, `ov`=0, state=IDLE, `start_d`=0.
- Launch at edge E0: `busy`=1 after E0.
- Partial-product updates occur at edges E1 through EW.
- After edge EW: `busy`=0, `valid`=1, `Q` and `ov` final. Latency is W cycles (10 cycles at W=10).
- `valid` and `busy` are never high together.
- A relaunch from DONE drops `valid` on the same edge that raises `busy`.
- `rst` mid-RUN: on the next edge all outputs return to reset values and any partial result is discarded.
- `rst` and a `start` rising edge in the same cycle: reset wins, and no launch occurs. Because `start_d` resets to 0, `start` still high in the following cycle counts as a rising edge and launches.

## Structure
- Shared package `mul_div_pkg` holds:
  - `W` and `FRAC` defaults, shared with the divider;
  - the state enum {IDLE, RUN, DONE}.
- Optional sub-module `seq_mul_dp` holds `acc`, `a_r`, `b_r` and `cnt` (shift/add datapath with load/step/done signals).
- `seq_mul_top` keeps the FSM, `start` edge detection and the output registers.

## Test plan
- Nominal: `A`=0001100000 (3.0), `B`=0001010000 (2.5), single `start` pulse. Expect `busy` for 10 cycles, then `valid`=1, `Q`=0011110000 (7.5), `ov`=0.
- Overflow: `A`=`B`=1111111111. Expect `valid`=1, `ov`=1, `Q`=1111000000 (truncated low bits).
- Truncation and zero:
  - `A`=0000000001, `B`=0000000001: expect `Q`=0, `ov`=0.
  - `A`=0, `B`=1011011110: expect `Q`=0, `ov`=0.
- Held start: hold `start` high for 30 cycles. Expect exactly one 10-cycle `busy` window, and `valid` stays 1 with the result unchanged.
- Busy collision: pulse `start` low then high at cycle 4 of RUN. Expect it ignored, original result at cycle 10, no second `busy` window.
- Reset mid-op: assert `rst` at RUN cycle 5. Expect `busy`, `valid`, `ov` and `Q` all 0 the next cycle; a following launch produces a correct result.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiplier and divider pair.
// Holds the default operand format and the launch/run/done state encoding.
// Both blocks import this so they stay interchangeable behind one controller.
package mul_div_pkg;

  localparam int W_DEF    = 10;
  localparam int FRAC_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: accumulates one partial product per step.
// Latency: W steps after load; prod/ovf reflect the accumulator including the current step.
// No backpressure: the controller drives load/step, and the datapath holds when neither is set.
module seq_mul_dp #(
  parameter int W    = 10,
  parameter int FRAC = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] prod,
  output logic         ovf,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] a_r;
  logic [W-1:0]   b_r;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc_nxt;

  // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nxt = acc;
    if (b_r[0]) begin
      acc_nxt = acc + a_r;
    end
  end

  // The final step's product is taken from acc_nxt so the result is ready on the same edge.
  assign prod = acc_nxt[FRAC+W-1:FRAC];
  assign ovf  = |acc_nxt[2*W-1:FRAC+W];
  assign last = (cnt == CW'(W - 1));

  // Operand load on launch, then one shift/add per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      a_r <= {{W{1'b0}}, a_in};
      b_r <= b_in;
      cnt <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_mul_top.sv
// Sequential fixed-point multiplier, Q = (A*B) >> FRAC truncated, with overflow flag.
// Latency: W cycles from the launching start edge to valid.
// No backpressure: start edges during a run are dropped; valid is sticky until the next launch.
module seq_mul_top
  import mul_div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic         busy,
  output logic         valid,
  output logic         ov
);

  state_t       state;
  logic         start_d;
  logic         launch;
  logic         step;
  logic         last;
  logic         ovf;
  logic [W-1:0] prod;

  // Only a rising edge of start launches, and never while a run is in progress.
  assign launch = start && !start_d && (state != RUN);
  assign step   = (state == RUN);

  seq_mul_dp #(
    .W    (W),
    .FRAC (FRAC)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .step (step),
    .a_in (A),
    .b_in (B),
    .prod (prod),
    .ovf  (ovf),
    .last (last)
  );

  // Control FSM with registered busy/valid/Q/ov; reset takes priority over a launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_d <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      ov      <= 1'b0;
      Q       <= '0;
    end else begin
      start_d <= start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state <= RUN;
            busy  <= 1'b1;
            valid <= 1'b0;
            ov    <= 1'b0;
          end
        end
        RUN: begin
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
            Q     <= prod;
            ov    <= ovf;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_top.sv
// Bench for seq_mul_top: cycle-level reference model plus directed literal checks.
// Latency: expects valid exactly W cycles after a launching start edge.
// No backpressure on the DUT; the bench drives start/rst directly.
module tb_seq_mul_top;

  localparam int W    = 10;
  localparam int FRAC = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic         busy;
  logic         valid;
  logic         ov;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  seq_mul_top #(
    .W    (W),
    .FRAC (FRAC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .busy  (busy),
    .valid (valid),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: event-level view of the protocol (launch, W-cycle countdown, result).
  bit           m_busy  = 0;
  bit           m_valid = 0;
  bit           m_ov    = 0;
  logic [W-1:0] m_q     = '0;
  bit           m_prev  = 0;
  int           m_left  = 0;
  logic [W-1:0] p_q;
  bit           p_ov;

  always @(posedge clk) begin
    bit      do_launch;
    longint  prod;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_ov = 0; m_q = '0; m_prev = 0; m_left = 0;
    end else begin
      do_launch = start && !m_prev && !m_busy;
      m_prev = start;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; m_valid = 1; m_q = p_q; m_ov = p_ov;
        end
      end
      if (do_launch) begin
        prod   = longint'(A) * longint'(B);
        p_q    = W'(prod >> FRAC);
        p_ov   = ((prod >> (FRAC + W)) != 0);
        m_busy = 1; m_valid = 0; m_ov = 0; m_left = W;
      end
    end
  end

  // Busy window bookkeeping for the directed tests.
  int  busy_cycles = 0;
  int  windows     = 0;
  bit  busy_prev   = 0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 5;
      if (busy !== m_busy) begin
        errors++; $display("FAIL model_busy: got %b expected %b at %0t", busy, m_busy, $time);
      end
      if (valid !== m_valid) begin
        errors++; $display("FAIL model_valid: got %b expected %b at %0t", valid, m_valid, $time);
      end
      if (Q !== m_q) begin
        errors++; $display("FAIL model_q: got %b expected %b at %0t", Q, m_q, $time);
      end
      if (ov !== m_ov) begin
        errors++; $display("FAIL model_ov: got %b expected %b at %0t", ov, m_ov, $time);
      end
      if (busy === 1'b1 && valid === 1'b1) begin
        errors++; $display("FAIL busy_valid_exclusive: busy=%b valid=%b at %0t", busy, valid, $time);
      end
    end
    if (busy === 1'b1) busy_cycles++;
    if (busy === 1'b1 && !busy_prev) windows++;
    busy_prev = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    busy_cycles = 0;
    windows     = 0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: valid=%b after %0d cycles, required 1", name, valid, n);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    clear_counts();
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(name);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick();
    chk_en = 1;
    tick();
    chk("reset_q", 32'(Q), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_ov", 32'(ov), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: 3.0 * 2.5 = 7.5
    run_op("nominal", 10'b0001100000, 10'b0001010000);
    chk("nominal_q", 32'(Q), 32'b0011110000);
    chk("nominal_ov", 32'(ov), 32'd0);
    chk("nominal_busy_cycles", 32'(busy_cycles), 32'd10);
    chk("nominal_windows", 32'(windows), 32'd1);

    // Overflow: all ones squared, truncated low bits kept.
    run_op("overflow", 10'b1111111111, 10'b1111111111);
    chk("overflow_q", 32'(Q), 32'b1111000000);
    chk("overflow_ov", 32'(ov), 32'd1);

    // Truncation to zero and zero operand.
    run_op("trunc", 10'b0000000001, 10'b0000000001);
    chk("trunc_q", 32'(Q), 32'd0);
    chk("trunc_ov", 32'(ov), 32'd0);
    run_op("zero", 10'b0000000000, 10'b1011011110);
    chk("zero_q", 32'(Q), 32'd0);
    chk("zero_ov", 32'(ov), 32'd0);

    // Held start: one run only, result stays put.
    clear_counts();
    A = 10'b0001100000; B = 10'b0001010000; start = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("held_windows", 32'(windows), 32'd1);
    chk("held_busy_cycles", 32'(busy_cycles), 32'd10);
    chk("held_valid", 32'(valid), 32'd1);
    chk("held_q", 32'(Q), 32'b0011110000);
    start = 1'b0;
    tick();

    // Busy collision: a second start edge mid-run is dropped; operands changed after launch.
    clear_counts();
    A = 10'd200; B = 10'd40; start = 1'b1;
    tick();
    start = 1'b0;
    A = 10'd1023; B = 10'd1023;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("collision");
    chk("collision_q", 32'(Q), 32'd250);
    chk("collision_ov", 32'(ov), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("collision_windows", 32'(windows), 32'd1);
    chk("collision_busy_cycles", 32'(busy_cycles), 32'd10);

    // Reset mid-run, then reset colliding with a start edge.
    A = 10'd64; B = 10'd64; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_ov", 32'(ov), 32'd0);
    chk("midrst_q", 32'(Q), 32'd0);
    start = 1'b1;
    tick();
    chk("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_launch_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_valid("post_rst");
    chk("post_rst_q", 32'(Q), 32'd128);
    chk("post_rst_ov", 32'(ov), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
